// File: rtl/debounce_pkg.sv
// Shared definitions for switch debouncing logic.
// Provides the debouncer FSM state encoding and the default
// counter width and synchroniser depth.
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_t;

  localparam int unsigned DEFAULT_N           = 20;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser for an asynchronous single-bit input.
// Every stage resets to 0.
//   clk   : destination clock
//   reset : asynchronous, active-high reset
//   d     : asynchronous input
//   q     : synchronised output, STAGES clk edges behind d
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Debounces a raw mechanical switch input. The input is first synchronised
// to clk. After that, a change of level is accepted only once it has held
// stable for 2**N cycles.
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high reset
//   sw       : raw switch input, asynchronous, may bounce
//   db_level : debounced level, decoded from registered state
//   db_busy  : high while a candidate transition is being timed
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned N           = DEFAULT_N,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_busy
);

  localparam logic [N-1:0] CNT_STEP = 1;

  logic         sw_s;
  db_state_t    state, state_next;
  logic [N-1:0] cnt, cnt_next;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (sw),
    .q    (sw_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ZERO;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A reversal of sw_s is tested before cnt==0, so a reversal arriving on the
  // final cycle of the window still aborts the transition.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ZERO: begin
        if (sw_s) begin
          cnt_next   = '1;
          state_next = WAIT1;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_next = ZERO;
        end else if (cnt == '0) begin
          state_next = ONE;
        end else begin
          cnt_next = cnt - CNT_STEP;
        end
      end
      ONE: begin
        if (!sw_s) begin
          cnt_next   = '1;
          state_next = WAIT0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_next = ONE;
        end else if (cnt == '0) begin
          state_next = ZERO;
        end else begin
          cnt_next = cnt - CNT_STEP;
        end
      end
      default: state_next = ZERO;
    endcase
  end

  // Outputs depend only on the state register, never combinationally on sw.
  assign db_level = (state == ONE) || (state == WAIT0);
  assign db_busy  = (state == WAIT1) || (state == WAIT0);

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce at N=3, SYNC_STAGES=2.
// A run-length reference model predicts {db_level, db_busy} after each
// clock edge. Predictions are queued and then compared against the DUT.
module tb_switch_debounce;

  localparam int WIN = 8;  // 2**N with N=3

  logic clk = 1'b0;
  logic reset;
  logic sw;
  logic db_level;
  logic db_busy;

  int errors = 0;
  int checks = 0;

  logic [1:0] sb[$];

  // Reference model state: two-deep input delay, accepted level, and how many
  // consecutive edges the synchronised input has disagreed with that level.
  logic m_p1, m_p2, m_level;
  int   m_run;

  int   edge_no;
  int   last_rise, first_busy;
  logic prev_level, prev_busy;
  int   ticks;

  always #5 clk = ~clk;

  switch_debounce #(
    .N(3),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sw      (sw),
    .db_level(db_level),
    .db_busy (db_busy)
  );

  task automatic model_clear();
    m_p1    = 1'b0;
    m_p2    = 1'b0;
    m_level = 1'b0;
    m_run   = 0;
  endtask

  task automatic model_edge();
    logic s;
    if (reset) begin
      model_clear();
    end else begin
      s = m_p2;
      if (s != m_level) begin
        m_run++;
        if (m_run == WIN + 1) begin
          m_level = s;
          m_run   = 0;
        end
      end else begin
        m_run = 0;
      end
      m_p2 = m_p1;
      m_p1 = sw;
    end
    sb.push_back({m_level, (m_run != 0)});
  endtask

  task automatic check_out(input string tag);
    logic [1:0] e;
    logic [1:0] o;
    o = {db_level, db_busy};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed=%b", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s: observed {level,busy}=%b expected=%b", tag, o, e);
      end
    end
  endtask

  task automatic cyc(input logic v, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sw = v;
      @(posedge clk);
      model_edge();
      #1;
      check_out(tag);
      if (db_level && !prev_level) begin
        last_rise = edge_no;
        ticks++;
      end
      if (db_busy && !prev_busy && first_busy < 0) first_busy = edge_no;
      prev_level = db_level;
      prev_busy  = db_busy;
      edge_no++;
    end
  endtask

  task automatic mark(input int start);
    edge_no    = start;
    last_rise  = -1;
    first_busy = -1;
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  initial begin
    prev_level = 1'b0;
    prev_busy  = 1'b0;
    ticks      = 0;
    mark(0);
    model_clear();

    // 1. reset held with sw=1, then release
    reset = 1'b1;
    sw    = 1'b1;
    #1;
    sb.push_back(2'b00);
    check_out("reset_async");
    cyc(1'b1, 3, "reset_hold");
    reset = 1'b0;
    mark(0);
    cyc(1'b1, 12, "t1_rise");
    check_int("t1_busy_edge", first_busy, 2);
    check_int("t1_rise_edge", last_rise, 10);

    // 2. bounce during rise-window
    cyc(1'b0, 14, "t2_settle_low");
    cyc(1'b1, 4, "t2_bounce_hi");
    cyc(1'b0, 1, "t2_bounce_lo");
    mark(0);
    cyc(1'b1, 12, "t2_final_rise");
    check_int("t2_rise_edge", last_rise, 10);

    // 3. from ONE: single-cycle low glitch, then stable low
    cyc(1'b0, 1, "t3_glitch");
    cyc(1'b1, 6, "t3_hold_hi");
    cyc(1'b0, 14, "t3_fall");

    // 4. reversal seen exactly when the counter reaches zero
    cyc(1'b1, 8, "t4_pulse8");
    cyc(1'b0, 8, "t4_abort");

    // 5. async reset in the middle of WAIT0
    cyc(1'b1, 12, "t5_rise");
    cyc(1'b0, 4, "t5_wait0");
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    sb.push_back(2'b00);
    check_out("t5_async_reset");
    prev_level = db_level;
    prev_busy  = db_busy;
    #2;
    cyc(1'b1, 2, "t5_reset_hold");
    reset = 1'b0;
    mark(0);
    cyc(1'b1, 12, "t5_full_window");
    check_int("t5_rise_edge", last_rise, 10);
    cyc(1'b0, 12, "t5_fall");

    // 6. three bouncy presses feeding a rising-edge detector
    ticks = 0;
    for (int p = 0; p < 3; p++) begin
      cyc(1'b1, 2, "t6_press_bounce");
      cyc(1'b0, 1, "t6_press_bounce");
      cyc(1'b1, 1, "t6_press_bounce");
      cyc(1'b0, 1, "t6_press_bounce");
      cyc(1'b1, 12, "t6_press_hold");
      cyc(1'b0, 1, "t6_rel_bounce");
      cyc(1'b1, 1, "t6_rel_bounce");
      cyc(1'b0, 12, "t6_rel_hold");
    end
    check_int("t6_ticks", ticks, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
